// File: rtl/rr4_sel64_pkg.sv
// rtl/rr4_sel64_pkg.sv - shared channel index / select code types for rr4_sel64
package rr4_pkg;

    typedef logic [1:0] ch_idx_t;
    typedef logic [1:0] sel_code_t;

    localparam sel_code_t SEL_CH0 = 2'b10;
    localparam sel_code_t SEL_CH1 = 2'b01;
    localparam sel_code_t SEL_CH2 = 2'b11;
    localparam sel_code_t SEL_CH3 = 2'b00;

    // Downstream selector's fixed channel encoding
    function automatic sel_code_t ch2code(ch_idx_t ch);
        case (ch)
            2'd0:    ch2code = SEL_CH0;
            2'd1:    ch2code = SEL_CH1;
            2'd2:    ch2code = SEL_CH2;
            default: ch2code = SEL_CH3;
        endcase
    endfunction

endpackage

// File: rtl/rr4_sel64_if.sv
// rtl/rr4_sel64_if.sv - four source channels plus registered output stream of rr4_sel64
interface rr4_sel64_if #(parameter int W = 64);

    logic [W-1:0] y0;
    logic [W-1:0] y1;
    logic [W-1:0] y2;
    logic [W-1:0] y3;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [W-1:0] z;
    logic [1:0]   x;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output y0, y1, y2, y3, in_valid, out_ready,
        input  in_ready, z, x, out_valid
    );

    modport slave (
        input  y0, y1, y2, y3, in_valid, out_ready,
        output in_ready, z, x, out_valid
    );

endinterface

// File: rtl/rr4_sel64_arb.sv
// rtl/rr4_sel64_arb.sv - combinational 4-way round-robin grant starting after ptr
module rr_arb4
    import rr4_pkg::*;
(
    input  logic [3:0] in_valid_i,
    input  ch_idx_t    ptr_i,
    output logic [3:0] grant_o,
    output ch_idx_t    idx_o,
    output logic       found_o
);

    ch_idx_t cand;

    // Scan ptr+1 .. ptr+4; the last candidate wraps back to ptr itself
    always_comb begin
        found_o = 1'b0;
        idx_o   = ptr_i;
        cand    = ptr_i;
        for (int k = 1; k <= 4; k++) begin
            cand = ptr_i + 2'(k);
            if (!found_o && in_valid_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
        grant_o = found_o ? (4'b0001 << idx_o) : 4'b0000;
    end

endmodule

// File: rtl/rr4_sel64.sv
// rtl/rr4_sel64.sv - round-robin 4:1 register stage; RR4_BURST_EN enables owner bursts up to BURST beats
module rr4_sel64
    import rr4_pkg::*;
#(
    parameter int W     = 64,
    parameter int BURST = 4
) (
    input  logic       clk,
    input  logic       rst,
    rr4_sel64_if.slave bus
);

    if (BURST < 1) begin : g_burst_chk
        $error("BURST must be >= 1");
    end

    logic [W-1:0] z_q, z_d;
    sel_code_t    x_q, x_d;
    logic         ov_q, ov_d;
    ch_idx_t      ptr_q, ptr_d;

    logic [3:0]   arb_grant;
    ch_idx_t      arb_idx;
    logic         arb_found;
    ch_idx_t      gnt_idx;
    logic         gnt_found;
    logic         free;
    logic [W-1:0] sel_data;

    rr_arb4 u_arb (
        .in_valid_i (bus.in_valid),
        .ptr_i      (ptr_q),
        .grant_o    (arb_grant),
        .idx_o      (arb_idx),
        .found_o    (arb_found)
    );

`ifdef RR4_BURST_EN
    localparam int CW = $clog2(BURST + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          keep;

    // Current owner keeps the grant while it still offers data and has budget left
    assign keep      = bus.in_valid[ptr_q] && (cnt_q < CW'(BURST));
    assign gnt_idx   = keep ? ptr_q : arb_idx;
    assign gnt_found = keep | arb_found;
`else
    assign gnt_idx   = arb_idx;
    assign gnt_found = arb_found;
`endif

    assign free = ~ov_q | bus.out_ready;

    always_comb begin
        case (gnt_idx)
            2'd0:    sel_data = bus.y0;
            2'd1:    sel_data = bus.y1;
            2'd2:    sel_data = bus.y2;
            default: sel_data = bus.y3;
        endcase
    end

    always_comb begin
        z_d   = z_q;
        x_d   = x_q;
        ov_d  = ov_q;
        ptr_d = ptr_q;
`ifdef RR4_BURST_EN
        cnt_d = cnt_q;
`endif
        if (free) begin
            if (gnt_found) begin
                z_d   = sel_data;
                x_d   = ch2code(gnt_idx);
                ov_d  = 1'b1;
                ptr_d = gnt_idx;
`ifdef RR4_BURST_EN
                cnt_d = keep ? cnt_q + CW'(1) : CW'(1);
`endif
            end else begin
                ov_d = 1'b0;
`ifdef RR4_BURST_EN
                cnt_d = '0;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_q   <= '0;
            x_q   <= 2'b00;
            ov_q  <= 1'b0;
            ptr_q <= 2'd3;
`ifdef RR4_BURST_EN
            cnt_q <= '0;
`endif
        end else begin
            z_q   <= z_d;
            x_q   <= x_d;
            ov_q  <= ov_d;
            ptr_q <= ptr_d;
`ifdef RR4_BURST_EN
            cnt_q <= cnt_d;
`endif
        end
    end

    assign bus.in_ready  = (!rst && free && gnt_found) ? arb_grant_or_keep(gnt_idx) : 4'b0000;
    assign bus.z         = z_q;
    assign bus.x         = x_q;
    assign bus.out_valid = ov_q;

    function automatic logic [3:0] arb_grant_or_keep(ch_idx_t idx);
        arb_grant_or_keep = 4'b0001 << idx;
    endfunction

endmodule
